// File: rtl/led_seq_pkg.sv
// Shared types and helpers for the LED pattern sequencer: phase codes,
// run-mode codes, per-phase step counts and the per-step LED pattern.
package led_seq_pkg;

    localparam int unsigned PAT_MAX_W = 64;

    typedef enum logic [2:0] {
        PH_BLANK  = 3'd0,
        PH_WALK   = 3'd1,
        PH_FILL   = 3'd2,
        PH_BOUNCE = 3'd3,
        PH_BLINK  = 3'd4,
        PH_HALVES = 3'd5,
        PH_GAP    = 3'd6
    } phase_e;

    localparam logic [1:0] MODE_AUTO   = 2'd0;
    localparam logic [1:0] MODE_LOOP   = 2'd1;
    localparam logic [1:0] MODE_STEP   = 2'd2;
    localparam logic [1:0] MODE_FREEZE = 2'd3;

    // Number of steps spent in a phase
    function automatic int unsigned phase_len(input phase_e ph, input int unsigned w,
                                              input int unsigned blink_n,
                                              input int unsigned half_n,
                                              input int unsigned gap_n);
        int unsigned len;
        case (ph)
            PH_WALK, PH_FILL: len = w;
            PH_BOUNCE:        len = 2 * w;
            PH_BLINK:         len = blink_n;
            PH_HALVES:        len = half_n;
            PH_GAP:           len = gap_n;
            default:          len = 1;
        endcase
        return len;
    endfunction

    // Longest phase; sizes the step index
    function automatic int unsigned max_phase_len(input int unsigned w,
                                                  input int unsigned blink_n,
                                                  input int unsigned half_n,
                                                  input int unsigned gap_n);
        int unsigned m;
        m = 2 * w;
        if (blink_n > m) m = blink_n;
        if (half_n > m)  m = half_n;
        if (gap_n > m)   m = gap_n;
        return m;
    endfunction

    // Phase order of the show, GAP wraps back to BLANK
    function automatic phase_e next_phase(input phase_e ph);
        phase_e nx;
        case (ph)
            PH_BLANK:  nx = PH_WALK;
            PH_WALK:   nx = PH_FILL;
            PH_FILL:   nx = PH_BOUNCE;
            PH_BOUNCE: nx = PH_BLINK;
            PH_BLINK:  nx = PH_HALVES;
            PH_HALVES: nx = PH_GAP;
            default:   nx = PH_BLANK;
        endcase
        return nx;
    endfunction

    // LED pattern for step k of a phase; only the low w bits are meaningful
    function automatic logic [PAT_MAX_W-1:0] led_pattern(input phase_e ph, input int unsigned k,
                                                         input int unsigned w);
        logic [PAT_MAX_W-1:0] ones;
        logic [PAT_MAX_W-1:0] lo;
        logic [PAT_MAX_W-1:0] pat;
        ones = {PAT_MAX_W{1'b1}} >> (PAT_MAX_W - w);
        lo   = ones >> (w / 2);
        pat  = '0;
        case (ph)
            PH_WALK:   pat = PAT_MAX_W'(1) << (w - 1 - k);
            PH_FILL:   pat = (ones << k) & ones;
            PH_BOUNCE: pat = (k < w) ? (PAT_MAX_W'(1) << (w - 1 - k)) : (PAT_MAX_W'(1) << (k - w));
            PH_BLINK:  pat = k[0] ? '0 : ones;
            PH_HALVES: pat = k[0] ? (lo << (w / 2)) : lo;
            default:   pat = '0;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/led_seq_prescaler.sv
// Free-running step-rate prescaler with a speed-selectable strobe.
module led_seq_prescaler #(
    parameter int unsigned PRESCALE_W = 23
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_speed,
    output logic [2:0] o_pre_lo,
    output logic       o_tick_c
);

    logic [PRESCALE_W-1:0] r_pre;
    logic [PRESCALE_W-1:0] w_mask;

    // Counter wraps naturally; never cleared except by reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PRESCALE_W'(1);
        end
    end

    // Each speed step halves the period by dropping one compared MSB
    assign w_mask   = {PRESCALE_W{1'b1}} >> i_speed;
    assign o_tick_c = &(r_pre | ~w_mask);
    assign o_pre_lo = r_pre[2:0];

endmodule

// File: rtl/led_pattern_seq.sv
// Seven-phase LED show sequencer with AUTO/LOOP/STEP/FREEZE run modes.
// Optional macro LEDSEQ_PWM_EN gates the LED register with a dim duty cycle.
module led_pattern_seq
    import led_seq_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PRESCALE_W = 23,
    parameter int unsigned BLINK_N    = 21,
    parameter int unsigned HALF_N     = 17,
    parameter int unsigned GAP_N      = 31
) (
    input  logic             clk25,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [1:0]       speed,
    input  logic             step,
    input  logic [2:0]       dim,
    output logic [WIDTH-1:0] leds,
    output logic [2:0]       phase,
    output logic             tick
);

    localparam int unsigned MAX_L = max_phase_len(WIDTH, BLINK_N, HALF_N, GAP_N);
    localparam int unsigned IDX_W = $clog2(MAX_L);

    phase_e             r_phase;
    phase_e             w_phase_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic               r_step_q;
    logic [WIDTH-1:0]   r_leds;
    logic [WIDTH-1:0]   w_pat;
    logic [2:0]         w_pre_lo;
    logic               w_tick;
    logic               w_adv;
    logic               w_last;
    int unsigned        w_len;

    led_seq_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .i_clk    (clk25),
        .i_rst    (rst),
        .i_speed  (speed),
        .o_pre_lo (w_pre_lo),
        .o_tick_c (w_tick)
    );

    assign w_len  = phase_len(r_phase, WIDTH, BLINK_N, HALF_N, GAP_N);
    assign w_last = (32'(r_idx) >= (w_len - 1));
    assign w_pat  = WIDTH'(led_pattern(r_phase, 32'(r_idx), WIDTH));

    // Phase and step-index state register
    always_ff @(posedge clk25) begin
        if (rst) begin
            r_phase <= PH_BLANK;
            r_idx   <= '0;
        end else begin
            r_phase <= w_phase_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Advance decision and next phase/index; illegal codes fall back to BLANK
    always_comb begin
        w_phase_nxt = r_phase;
        w_idx_nxt   = r_idx;
        w_adv       = 1'b0;
        case (mode)
            MODE_AUTO, MODE_LOOP: w_adv = w_tick;
            MODE_STEP:            w_adv = step & ~r_step_q;
            default:              w_adv = 1'b0;
        endcase
        case (r_phase)
            PH_BLANK, PH_WALK, PH_FILL, PH_BOUNCE, PH_BLINK, PH_HALVES, PH_GAP: begin
                if (w_adv) begin
                    if (!w_last) begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end else begin
                        w_idx_nxt = '0;
                        if (mode != MODE_LOOP) begin
                            w_phase_nxt = next_phase(r_phase);
                        end
                    end
                end
            end
            default: begin
                w_phase_nxt = PH_BLANK;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Step edge history and registered LED output
    always_ff @(posedge clk25) begin
        if (rst) begin
            r_step_q <= 1'b0;
            r_leds   <= '0;
        end else begin
            r_step_q <= step;
`ifdef LEDSEQ_PWM_EN
            r_leds   <= w_pat & {WIDTH{w_pre_lo <= dim}};
`else
            r_leds   <= w_pat;
`endif
        end
    end

`ifndef LEDSEQ_PWM_EN
    // Dimming inputs have no effect without PWM
    logic w_unused_pwm;
    assign w_unused_pwm = ^{dim, w_pre_lo};
`endif

    assign leds  = r_leds;
    assign phase = r_phase;
    assign tick  = w_tick;

endmodule

// File: doc/led_pattern_seq.md
# led_pattern_seq

Parametrised LED pattern sequencer for the funnyblinky tile. It steps a `WIDTH`-bit LED bank through a fixed seven-phase show:
- blank
- walk
- fill
- bounce
- blink
- halves
- gap

A power-of-two prescaler sets the step rate. Run modes are auto, loop-phase, single-step and freeze, and the output is registered. It sits between the tile's `io_in` decode (clock on `io_in[0]`, control pins) and `io_out`.

## Interface
- `WIDTH`, 8: LED count; even, ≥ 4.
- `PRESCALE_W`, 23: prescaler bits; base step period 2^PRESCALE_W cycles; ≥ 4.
- `BLINK_N`, 21: steps in BLINK phase.
- `HALF_N`, 17: steps in HALVES phase.
- `GAP_N`, 31: steps in GAP phase.

Ports (clock and reset first):
- `clk25`  in  1  sole clock.
- `rst`  in  1  reset; synchronous, active-high.
- `mode`  in  2  0 AUTO, 1 LOOP, 2 STEP, 3 FREEZE.
- `speed`  in  2  rate select; step period 2^(PRESCALE_W−speed).
- `step`  in  1  manual advance, level; rising edge used in STEP mode.
- `dim`  in  3  PWM duty; only used with `LEDSEQ_PWM_EN`.
- `leds`  out  WIDTH  registered LED pattern.
- `phase`  out  3  current phase code.
- `tick`  out  1  prescaler strobe, one cycle wide.

## Operation
- **Prescaler `pre`:** PRESCALE_W bits, free-running, +1 every cycle, wraps.
  - `tick` = 1 when `pre[PRESCALE_W−1−speed:0]` is all ones.
- **Phase FSM and step index `idx`:** phases, their lengths L, and the pattern for index k:
  - BLANK(0): L=1; 0.
  - WALK(1): L=W; 1<<(W−1−k).
  - FILL(2): L=W; all-ones<<k, truncated to W bits.
  - BOUNCE(3): L=2W; k<W gives 1<<(W−1−k), else 1<<(k−W).
  - BLINK(4): L=BLINK_N; k even gives all ones, odd gives 0.
  - HALVES(5): L=HALF_N; k even gives low W/2 bits set, odd gives high W/2 bits set.
  - GAP(6): L=GAP_N; 0.
- **Advance condition:**
  - AUTO or LOOP: advance when `tick`.
  - STEP: advance on `step` rising edge (`step` & ~`step_q`); `tick` ignored.
  - FREEZE: never advance.
- **On advance:**
  - If idx<L−1: idx+1.
  - Else idx=0, and the phase goes to the next one (GAP→BLANK). In LOOP the phase is unchanged.
- **Mode change:** takes effect at the next advance. Neither idx nor phase is cleared.
- **Default period:** W=8 gives a 102-step sequence.
- **`phase` output:** the current FSM phase, unregistered copy of the state register.
- **Out-of-range code:** an illegal phase code (7) recovers to BLANK with idx=0 on the next cycle.

## Timing
- **Reset values:** on the cycle after `rst`=1:
  - `pre`=0, phase=BLANK, idx=0, `step_q`=0.
  - `leds`=0, `tick`=0, `phase`=0.
  - `rst` overrides any advance in the same cycle.
- **Latency:** phase/idx update on the clock edge ending the advance cycle. `leds` reflects the new phase/idx one cycle later (registered pattern).
- **Step edge:** `step_q` registered each cycle. An edge coinciding with `tick` in STEP mode yields exactly one advance.
- **Reset mid-operation:** reset mid-phase returns to BLANK regardless of mode.
- **Speed change:** takes effect immediately on the tick compare. `pre` is not cleared.

## Configuration
- **`LEDSEQ_PWM_EN` defined:** output register loads pattern & {W{`pre[2:0]` ≤ `dim`}}.
  - `dim`=7 is full on; `dim`=0 is on 1 cycle in 8.
- **`LEDSEQ_PWM_EN` undefined:** `dim` is ignored; `leds` = pattern.

## Structure
- **Package `led_seq_pkg`:**
  - Phase enum (3-bit).
  - Mode constants.
  - Phase-length function (W, BLINK_N, HALF_N, GAP_N).
  - Pattern function (phase, idx, W).
- **Sub-module `led_seq_prescaler`:** `pre` counter plus `tick` compare, parametrised by PRESCALE_W, with `speed` input.
- **Top:** FSM, step edge detect, output register.

## Test plan
All scenarios use PRESCALE_W=4, W=8.
1. Reset: `rst`=1 for 3 cycles with `mode`=AUTO → `leds`=0x00, `phase`=0, `tick`=0. After release, first `tick` at cycle 16 with `speed`=0.
2. AUTO, `speed`=3 (tick every 2 cycles):
   - `leds` sequence 0x00, 0x80, 0x40 … 0x01, then 0xFF, 0xFE … 0x80.
   - After 102 advances, `phase`=0 and `leds`=0x00.
3. STEP: hold `step`=1 for 10 cycles → exactly one advance (BLANK→WALK, `leds`=0x80). Three 1-cycle pulses → `leds`=0x10.
4. LOOP entered in BLINK → `leds` alternates 0xFF/0x00. At idx 20→0, `phase` stays 4 and the next pattern is 0xFF.
5. FREEZE mid-BOUNCE holds `leds` for 50 cycles. Then `rst` for 1 cycle → BLANK, `leds`=0x00 next cycle.
6. `LEDSEQ_PWM_EN`, `dim`=0, in FILL k=0 → `leds`=0xFF only when `pre[2:0]`=0, else 0x00. With `dim`=7 → 0xFF constant.
